// File: rtl/sr_chain_frame_sequencer_if.sv
// I/Q sample stream handshake between the sample source and the frame sequencer.
// The source is the master; the sequencer is the slave.
interface sr_chain_frame_sequencer_if #(
    parameter int DATA_W = 10
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_i;
    logic signed [DATA_W-1:0] in_q;

    modport master (output in_valid, output in_i, output in_q, input in_ready);
    modport slave  (input in_valid, input in_i, input in_q, output in_ready);
endinterface

// File: rtl/sr_chain_frame_sequencer.sv
// Frame sequencer for the dual I/Q shift-register sorting chains: fill, settle, MLP trigger, wait.
// Optional MLP watchdog is compiled in with `define SR_SEQ_TIMEOUT_EN.
module sr_chain_frame_sequencer #(
    parameter int N       = 1000,
    parameter int SETTLE  = 2,
    parameter int TIMEOUT = 4096,
    parameter int DATA_W  = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     abort,
    sr_chain_frame_sequencer_if.slave s_if,
    output logic signed [DATA_W-1:0] out_i,
    output logic signed [DATA_W-1:0] out_q,
    output logic [N:0]               enable,
    output logic                     mlp_en,
    input  logic                     mlp_done,
    // 'final' is a reserved word in SystemVerilog, hence the suffix.
    output logic                     final_pulse,
    output logic                     busy,
    output logic [15:0]              frame_cnt,
    output logic                     timeout
);

    localparam int CW = $clog2(N + 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FILL   = 3'd1;
    localparam logic [2:0] ST_SETTLE = 3'd2;
    localparam logic [2:0] ST_TRIG   = 3'd3;
    localparam logic [2:0] ST_WAIT   = 3'd4;

    localparam logic [CW-1:0] N_LAST      = CW'(N - 1);
    localparam logic [3:0]    SETTLE_LAST = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);

    if (N < 1 || SETTLE < 0 || SETTLE > 15 || TIMEOUT < 1) begin : g_bad_param
        $error("sr_chain_frame_sequencer: illegal N, SETTLE or TIMEOUT");
    end

    logic [2:0]    state;
    logic [CW-1:0] sample_cnt;
    logic [3:0]    settle_cnt;
    logic          accept;

    assign s_if.in_ready = (state == ST_FILL);
    assign accept        = s_if.in_valid & s_if.in_ready;
    assign mlp_en        = (state == ST_TRIG);
    assign busy          = (state != ST_IDLE);

`ifdef SR_SEQ_TIMEOUT_EN
    logic [15:0] wd_cnt;
    logic        timeout_r;
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

    assign timeout = timeout_r;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            sample_cnt  <= '0;
            settle_cnt  <= '0;
            enable      <= '0;
            out_i       <= '0;
            out_q       <= '0;
            final_pulse <= 1'b0;
            frame_cnt   <= '0;
`ifdef SR_SEQ_TIMEOUT_EN
            wd_cnt      <= '0;
            timeout_r   <= 1'b0;
`endif
        end else begin
            final_pulse <= 1'b0;
`ifdef SR_SEQ_TIMEOUT_EN
            timeout_r   <= 1'b0;
`endif
            // Abort outranks every other event; in IDLE it also swallows a coincident start.
            if (abort && state != ST_IDLE) begin
                state  <= ST_IDLE;
                enable <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start && !abort) begin
                            state      <= ST_FILL;
                            enable     <= '0;
                            sample_cnt <= '0;
                        end
                    end
                    ST_FILL: begin
                        if (accept) begin
                            out_i      <= s_if.in_i;
                            out_q      <= s_if.in_q;
                            enable     <= {enable[N-1:0], 1'b1};
                            sample_cnt <= sample_cnt + 1'b1;
                            if (sample_cnt == N_LAST) begin
                                state      <= ST_SETTLE;
                                settle_cnt <= '0;
                            end
                        end
                    end
                    ST_SETTLE: begin
                        if (settle_cnt == SETTLE_LAST) begin
                            state <= ST_TRIG;
                        end else begin
                            settle_cnt <= settle_cnt + 4'd1;
                        end
                    end
                    ST_TRIG: begin
                        state <= ST_WAIT;
`ifdef SR_SEQ_TIMEOUT_EN
                        wd_cnt <= '0;
`endif
                    end
                    ST_WAIT: begin
                        if (mlp_done) begin
                            state       <= ST_IDLE;
                            final_pulse <= 1'b1;
                            frame_cnt   <= frame_cnt + 16'd1;
`ifdef SR_SEQ_TIMEOUT_EN
                        end else if (wd_cnt == WD_LAST) begin
                            state     <= ST_IDLE;
                            enable    <= '0;
                            timeout_r <= 1'b1;
                        end else begin
                            wd_cnt <= wd_cnt + 16'd1;
`endif
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sr_chain_frame_sequencer.sv
// Scoreboard bench for sr_chain_frame_sequencer with N=4, SETTLE=2 and directed frames.
module tb_sr_chain_frame_sequencer;

    localparam int N       = 4;
    localparam int SETTLE  = 2;
    localparam int TIMEOUT = 8;
    localparam int DATA_W  = 10;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     start;
    logic                     abort;
    logic                     mlp_done;
    logic signed [DATA_W-1:0] out_i;
    logic signed [DATA_W-1:0] out_q;
    logic [N:0]               enable;
    logic                     mlp_en;
    logic                     final_pulse;
    logic                     busy;
    logic [15:0]              frame_cnt;
    logic                     timeout;

    sr_chain_frame_sequencer_if #(.DATA_W(DATA_W)) s_if ();

    sr_chain_frame_sequencer #(
        .N(N), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT), .DATA_W(DATA_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .s_if(s_if),
        .out_i(out_i), .out_q(out_q), .enable(enable), .mlp_en(mlp_en),
        .mlp_done(mlp_done), .final_pulse(final_pulse), .busy(busy),
        .frame_cnt(frame_cnt), .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [DATA_W-1:0] i;
        logic signed [DATA_W-1:0] q;
        logic [N:0]               en;
    } samp_t;

    samp_t       samp_q[$];
    int          mlp_q[$];
    logic [15:0] fin_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Monitor: compares every DUT event against the expectation queues.
    int    cyc = 0;
    int    last_acc = 0;
    logic  acc_prev = 1'b0;
    samp_t s_exp;
    int    m_exp;
    logic [15:0] f_exp;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (acc_prev) begin
            if (samp_q.size() == 0) begin
                check("unexpected_sample", 32'd1, 32'd0);
            end else begin
                s_exp = samp_q.pop_front();
                check("out_i", out_i, s_exp.i);
                check("out_q", out_q, s_exp.q);
                check("enable", enable, s_exp.en);
            end
        end
        acc_prev = s_if.in_valid && s_if.in_ready && !abort && !reset;
        if (acc_prev) last_acc = cyc;
        if (mlp_en) begin
            if (mlp_q.size() == 0) begin
                check("unexpected_mlp_en", 32'd1, 32'd0);
            end else begin
                m_exp = mlp_q.pop_front();
                check("mlp_en_latency", cyc - last_acc, m_exp);
            end
        end
        if (final_pulse) begin
            if (fin_q.size() == 0) begin
                check("unexpected_final", 32'd1, 32'd0);
            end else begin
                f_exp = fin_q.pop_front();
                check("final_frame_cnt", frame_cnt, f_exp);
            end
        end
`ifndef SR_SEQ_TIMEOUT_EN
        if (timeout) check("timeout_tied_low", timeout, 32'd0);
`endif
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input int i, input int q, input logic v, input logic [N:0] en_exp);
        samp_t s;
        s_if.in_valid = v;
        s_if.in_i     = DATA_W'(i);
        s_if.in_q     = DATA_W'(q);
        if (v) begin
            s.i  = DATA_W'(i);
            s.q  = DATA_W'(q);
            s.en = en_exp;
            samp_q.push_back(s);
        end
        step();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_mlp();
        for (int k = 0; k < 20 && !mlp_en; k++) step();
        if (!mlp_en) check("mlp_en_wait_expired", 32'd0, 32'd1);
    endtask

    task automatic finish_frame(input int done_delay, input logic [15:0] fc);
        wait_mlp();
        repeat (done_delay) step();
        fin_q.push_back(fc);
        mlp_done = 1'b1;
        step();
        mlp_done = 1'b0;
        step();
    endtask

    task automatic full_frame(input int base_i, input int base_q);
        feed(base_i + 0, base_q + 0, 1'b1, 5'b00001);
        feed(base_i + 1, base_q + 1, 1'b1, 5'b00011);
        feed(base_i + 2, base_q + 2, 1'b1, 5'b00111);
        mlp_q.push_back(SETTLE + 1);
        feed(base_i + 3, base_q + 3, 1'b1, 5'b01111);
        s_if.in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1, "time limit");
    end

    logic [1:0]  pat_v [7];
    logic [N:0]  held_en;
    logic signed [DATA_W-1:0] held_i;
    int          acc_n;

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; mlp_done = 1'b0;
        s_if.in_valid = 1'b0; s_if.in_i = '0; s_if.in_q = '0;
        #2;
        check("rst_enable", enable, 32'd0);
        check("rst_out_i", out_i, 32'd0);
        check("rst_out_q", out_q, 32'd0);
        check("rst_busy", busy, 32'd0);
        check("rst_frame_cnt", frame_cnt, 32'd0);
        check("rst_in_ready", s_if.in_ready, 32'd0);
        check("rst_mlp_en", mlp_en, 32'd0);
        check("rst_final", final_pulse, 32'd0);
        step();
        reset = 1'b0;
        step();
        check("idle_busy", busy, 32'd0);

        // Frame 1: continuous valid, samples 1..4 / 11..14, done 5 cycles after mlp_en.
        pulse_start();
        check("fill_busy", busy, 32'd1);
        check("fill_in_ready", s_if.in_ready, 32'd1);
        full_frame(1, 11);
        check("settle_in_ready", s_if.in_ready, 32'd0);
        finish_frame(5, 16'd1);
        check("f1_busy_after", busy, 32'd0);
        check("f1_frame_cnt", frame_cnt, 32'd1);

        // Frame 2: in_valid pattern 1,0,0,1,1,0,1.
        pat_v = '{2'd1, 2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd1};
        acc_n = 0;
        held_en = '0;
        held_i  = '0;
        pulse_start();
        for (int k = 0; k < 7; k++) begin
            if (pat_v[k] == 2'd1) begin
                acc_n++;
                held_en = {held_en[N-1:0], 1'b1};
                held_i  = DATA_W'(20 + acc_n);
                if (acc_n == N) mlp_q.push_back(SETTLE + 1);
                feed(20 + acc_n, 30 + acc_n, 1'b1, held_en);
            end else begin
                feed(99, 99, 1'b0, '0);
                check("hold_enable", enable, held_en);
                check("hold_out_i", out_i, held_i);
            end
        end
        s_if.in_valid = 1'b1;
        s_if.in_i = 10'sd99;
        check("after_4th_in_ready", s_if.in_ready, 32'd0);
        step();
        s_if.in_valid = 1'b0;
        finish_frame(1, 16'd2);
        check("f2_frame_cnt", frame_cnt, 32'd2);

        // Frame 3: start pulsed after 2 accepts is ignored.
        pulse_start();
        feed(41, 51, 1'b1, 5'b00001);
        feed(42, 52, 1'b1, 5'b00011);
        s_if.in_valid = 1'b0;
        pulse_start();
        check("restart_ignored_busy", busy, 32'd1);
        feed(43, 53, 1'b1, 5'b00111);
        mlp_q.push_back(SETTLE + 1);
        feed(44, 54, 1'b1, 5'b01111);
        s_if.in_valid = 1'b0;
        finish_frame(2, 16'd3);
        check("f3_frame_cnt", frame_cnt, 32'd3);

        // Frame 4: abort coincides with the 3rd accept.
        pulse_start();
        feed(61, 71, 1'b1, 5'b00001);
        feed(62, 72, 1'b1, 5'b00011);
        abort = 1'b1;
        s_if.in_valid = 1'b1;
        s_if.in_i = 10'sd63;
        s_if.in_q = 10'sd73;
        step();
        abort = 1'b0;
        s_if.in_valid = 1'b0;
        check("abort_busy", busy, 32'd0);
        check("abort_enable", enable, 32'd0);
        check("abort_in_ready", s_if.in_ready, 32'd0);
        repeat (8) step();
        check("abort_frame_cnt", frame_cnt, 32'd3);

        // start and abort together in IDLE: abort wins.
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_idle_busy", busy, 32'd0);

`ifdef SR_SEQ_TIMEOUT_EN
        // Watchdog: no mlp_done, timeout 8 cycles after entering WAIT.
        pulse_start();
        full_frame(81, 91);
        wait_mlp();
        step();
        repeat (7) step();
        check("wd_not_yet", timeout, 32'd0);
        step();
        check("wd_timeout", timeout, 32'd1);
        check("wd_busy", busy, 32'd0);
        check("wd_enable", enable, 32'd0);
        check("wd_frame_cnt", frame_cnt, 32'd3);
        step();
`endif

        // Frame 5: asynchronous reset while waiting for mlp_done.
        pulse_start();
        full_frame(101, 111);
        wait_mlp();
        step();
        step();
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_enable", enable, 32'd0);
        check("async_rst_out_i", out_i, 32'd0);
        check("async_rst_out_q", out_q, 32'd0);
        check("async_rst_busy", busy, 32'd0);
        check("async_rst_frame_cnt", frame_cnt, 32'd0);
        check("async_rst_mlp_en", mlp_en, 32'd0);
        check("async_rst_final", final_pulse, 32'd0);
        step();
        reset = 1'b0;
        step();
        mlp_done = 1'b1;
        step();
        mlp_done = 1'b0;
        step();
        check("late_done_busy", busy, 32'd0);
        check("late_done_frame_cnt", frame_cnt, 32'd0);

        repeat (3) step();
        check("samp_q_drained", samp_q.size(), 32'd0);
        check("mlp_q_drained", mlp_q.size(), 32'd0);
        check("fin_q_drained", fin_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sr_chain_frame_sequencer.md
Name: sr_chain_frame_sequencer

Overview:
- Frame-level controller for the dual (I/Q) shift-register sorting chains.
- Accepts an I/Q sample stream over a valid/ready handshake and forwards one registered sample per accepted beat to both chains.
- Drives the shared N+1-bit thermometer enable, then triggers the MLP stage and waits for its completion.
- Sits between the sample source and the sorting unit; replaces free-running enable generation with back-pressured, frame-counted sequencing.

Parameters:
- N, 1000, sorting chain length in samples per frame.
- SETTLE, 2, cycles between the last accepted sample and mlp_en, for chain pipeline flush; legal range 0..15.
- TIMEOUT, 4096, watchdog limit in cycles while waiting for mlp_done; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a frame when IDLE.
- abort  in  1  synchronous frame cancel.
- in_valid  in  1  sample valid.
- in_ready  out  1  sample ready.
- in_i  in  10  I sample.
- in_q  in  10  Q sample.
- out_i  out  10  registered I sample to chain 0.
- out_q  out  10  registered Q sample to chain 1.
- enable  out  N+1  thermometer enable to both chains.
- mlp_en  out  1  one-cycle MLP trigger.
- mlp_done  in  1  MLP completion pulse.
- final  out  1  one-cycle frame-complete pulse.
- busy  out  1  high whenever state is not IDLE.
- frame_cnt  out  16  count of completed frames; wraps at 0xFFFF to 0.
- timeout  out  1  watchdog pulse; tied 0 without the optional feature.

Behaviour:
- Reset: asynchronous, active-high. All outputs and registers go to 0: enable=0, out_i=out_q=0, frame_cnt=0, sample count=0, state=IDLE.
- States: IDLE, FILL, SETTLE, TRIG, WAIT.
- IDLE:
  - in_ready=0; enable holds its last value.
  - start=1 -> FILL; clears enable to 0 and the sample count to 0 on the same edge.
- FILL:
  - in_ready=1 combinationally in this state only.
  - Accept = in_valid & in_ready.
  - On accept: out_i<=in_i, out_q<=in_q, enable<={enable[N-1:0],1'b1}, count++.
  - With no accept: enable and out_* hold, and the chains see no new data.
  - When the accept that makes count==N occurs -> SETTLE, with settle counter=0.
- SETTLE:
  - in_ready=0.
  - Counts SETTLE cycles, then -> TRIG. With SETTLE=0, go to TRIG on the next edge.
- TRIG:
  - mlp_en=1 for exactly this one cycle, then -> WAIT.
- WAIT:
  - mlp_done=1 -> IDLE on the same edge; final=1 for the following cycle; frame_cnt++.
  - mlp_done in any state other than WAIT is ignored.
- Latency: the first accepted sample appears on out_i/out_q one cycle after accept. mlp_en rises SETTLE+1 cycles after the Nth accept.
- start while busy: ignored; no restart, no error.
- abort=1 in any non-IDLE state:
  - Next edge: state=IDLE, enable=0, no mlp_en, no final; frame_cnt unchanged.
  - abort has priority over accept, mlp_done and start in the same cycle.
  - abort in IDLE is a no-op.
- Simultaneous start+abort in IDLE: abort wins and start is dropped.
- Counter widths:
  - Sample count width is $clog2(N+1).
  - Settle counter is 4 bits.
  - frame_cnt is 16-bit, wrapping.
- Reset mid-frame discards the partial frame. No pulses are generated on reset release.

Optional Feature:
- Macro: SR_SEQ_TIMEOUT_EN.
- Defined:
  - A 16-bit watchdog counts cycles in WAIT.
  - If it reaches TIMEOUT with no mlp_done: timeout=1 for one cycle, state -> IDLE, enable cleared, no final, frame_cnt unchanged.
  - mlp_done arriving in the same cycle the limit is reached takes priority: normal completion, no timeout.
- Undefined: no watchdog logic; timeout is tied 0; WAIT waits indefinitely.

Test Plan:
- N=4, SETTLE=2, continuous in_valid, samples i=1..4, q=11..14:
  - out_i sequence is 1,2,3,4 with one-cycle lag.
  - enable steps 00001 -> 00011 -> 00111 -> 01111.
  - mlp_en pulses 3 cycles after the 4th accept.
  - mlp_done 5 cycles later -> final pulse, frame_cnt=1.
- N=4, in_valid toggled 1,0,0,1,1,0,1:
  - enable and out_* hold during low cycles.
  - Exactly 4 accepts occur; in_ready=0 after the 4th.
- start pulsed during FILL after 2 accepts: ignored; the frame completes normally after 2 further accepts.
- abort asserted on the same cycle as the 3rd accept (N=4): next cycle state is IDLE and enable=0; no mlp_en, no final; frame_cnt unchanged.
- reset asserted asynchronously mid-WAIT: all outputs are 0 immediately, before any clk edge; a later mlp_done is ignored.
- With SR_SEQ_TIMEOUT_EN, TIMEOUT=8, mlp_done never sent: timeout pulses 8 cycles after entering WAIT, busy falls, final stays 0.
